ysyx_25040111_lsu: RTL and testbench

Load/store and write-back stage directly downstream of the execute unit. It accepts one retired operation per valid/ready handshake. Memory operations go out on an AXI4-Lite-style data bus, with lane steering and sign extension. Every operation ends in a single-cycle GPR/CSR commit that also returns finish/frd to execute, which uses them to release read-after-write locks.

---
 rtl/ysyx_25040111_lsu.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_lsu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_lsu.sv
// Load/store and write-back stage.
// Accepts one retired op per handshake, runs an AXI4-Lite-style data
// transaction for loads/stores, and ends every op in a one-cycle commit
// that writes GPR/CSR and returns finish/frd to execute.
module ysyx_25040111_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_men,
    input  logic              in_write,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [1:0]        in_mask,
    input  logic              in_rsign,
    input  logic [4:0]        in_ard,
    input  logic [31:0]       in_rd,
    input  logic              in_gen,
    input  logic [11:0]       in_acsr,
    input  logic [31:0]       in_csr,
    input  logic              in_sen,
    input  logic [31:0]       in_pc,
    input  logic              in_err,
    input  logic [3:0]        in_errtp,

    output logic              finish,
    output logic [4:0]        frd,
    output logic              gpr_wen,
    output logic [4:0]        gpr_waddr,
    output logic [31:0]       gpr_wdata,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [31:0]       csr_wdata,
    output logic              err_o,
    output logic [3:0]        errtp_o,
    output logic [31:0]       err_pc,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RADDR  = 3'd1;
    localparam logic [2:0] S_RDATA  = 3'd2;
    localparam logic [2:0] S_WREQ   = 3'd3;
    localparam logic [2:0] S_WRESP  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    localparam logic [3:0] ET_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] ET_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] ET_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] ET_STORE_FAULT    = 4'd7;

    logic [2:0]        state;

    // Latched payload, stable from acceptance to commit
    logic              r_men;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_mask;
    logic              r_rsign;
    logic [4:0]        r_ard;
    logic [31:0]       r_rd;
    logic              r_gen;
    logic [11:0]       r_acsr;
    logic [31:0]       r_csr;
    logic              r_sen;
    logic [31:0]       r_pc;
    logic              r_err;
    logic [3:0]        r_errtp;

    // Locally detected exception and load result
    logic              r_exc;
    logic [3:0]        r_exctp;
    logic [31:0]       r_ldata;

    // Per-channel completion flags for the write request phase
    logic              aw_done;
    logic              w_done;

    logic              accept;
    logic              in_misalign;
    logic              aw_hs;
    logic              w_hs;
    logic              exc_all;
    logic [31:0]       rd_shifted;
    logic [31:0]       rd_ext;

    assign accept = in_valid & in_ready;
    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign exc_all = r_err | r_exc;

    // Alignment check on the offered address for the offered size
    always_comb begin
        in_misalign = 1'b0;
        case (in_mask)
            2'b00:   in_misalign = 1'b0;
            2'b01:   in_misalign = in_addr[0];
            default: in_misalign = (in_addr[1:0] != 2'b00);
        endcase
    end

    // Lane extraction and zero/sign extension of the returned read data
    always_comb begin
        rd_shifted = rdata >> {r_addr[1:0], 3'b000};
        rd_ext     = rd_shifted;
        case (r_mask)
            2'b00:   rd_ext = r_rsign ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                      : {24'h000000, rd_shifted[7:0]};
            2'b01:   rd_ext = r_rsign ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                      : {16'h0000, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // Store data lane replication and byte strobes
    always_comb begin
        wdata = r_wdata;
        wstrb = 4'b1111;
        case (r_mask)
            2'b00: begin
                wdata = {4{r_wdata[7:0]}};
                wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                wdata = {2{r_wdata[15:0]}};
                wstrb = 4'b0011 << r_addr[1:0];
            end
            default: begin
                wdata = r_wdata;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Bus, handshake and commit outputs decoded from state and latched payload
    always_comb begin
        in_ready  = reset & (state == S_IDLE);
        arvalid   = (state == S_RADDR);
        araddr    = {r_addr[ADDR_W-1:2], 2'b00};
        rready    = (state == S_RDATA);
        awvalid   = (state == S_WREQ) & ~aw_done;
        wvalid    = (state == S_WREQ) & ~w_done;
        awaddr    = {r_addr[ADDR_W-1:2], 2'b00};
        bready    = (state == S_WRESP);

        finish    = (state == S_COMMIT);
        frd       = (finish & r_gen) ? r_ard : 5'd0;
        gpr_wen   = finish & r_gen & ~exc_all & (r_ard != 5'd0);
        gpr_waddr = r_ard;
        gpr_wdata = (r_men & ~r_write) ? r_ldata : r_rd;
        csr_wen   = finish & r_sen & ~exc_all;
        csr_waddr = r_acsr;
        csr_wdata = r_csr;
        err_o     = finish & exc_all;
        errtp_o   = r_err ? r_errtp : r_exctp;
        err_pc    = r_pc;
    end

    // Main FSM: payload capture, bus sequencing and exception recording
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            r_men   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rsign <= 1'b0;
            r_ard   <= '0;
            r_rd    <= '0;
            r_gen   <= 1'b0;
            r_acsr  <= '0;
            r_csr   <= '0;
            r_sen   <= 1'b0;
            r_pc    <= '0;
            r_err   <= 1'b0;
            r_errtp <= '0;
            r_exc   <= 1'b0;
            r_exctp <= '0;
            r_ldata <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_men   <= in_men;
                        r_write <= in_write;
                        r_addr  <= in_addr;
                        r_wdata <= in_wdata;
                        r_mask  <= in_mask;
                        r_rsign <= in_rsign;
                        r_ard   <= in_ard;
                        r_rd    <= in_rd;
                        r_gen   <= in_gen;
                        r_acsr  <= in_acsr;
                        r_csr   <= in_csr;
                        r_sen   <= in_sen;
                        r_pc    <= in_pc;
                        r_err   <= in_err;
                        r_errtp <= in_errtp;
                        r_exc   <= 1'b0;
                        r_exctp <= '0;
                        r_ldata <= '0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (!in_men || in_err) begin
                            state <= S_COMMIT;
                        end else if (in_misalign) begin
                            r_exc   <= 1'b1;
                            r_exctp <= in_write ? ET_STORE_MISALIGN : ET_LOAD_MISALIGN;
                            state   <= S_COMMIT;
                        end else if (in_write) begin
                            state <= S_WREQ;
                        end else begin
                            state <= S_RADDR;
                        end
                    end
                end
                S_RADDR: begin
                    if (arready) state <= S_RDATA;
                end
                S_RDATA: begin
                    if (rvalid) begin
                        r_ldata <= rd_ext;
                        if (rresp != 2'b00) begin
                            r_exc   <= 1'b1;
                            r_exctp <= ET_LOAD_FAULT;
                        end
                        state <= S_COMMIT;
                    end
                end
                S_WREQ: begin
                    // Each channel completes independently; leave once both have
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WRESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            r_exc   <= 1'b1;
                            r_exctp <= ET_STORE_FAULT;
                        end
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed testbench for ysyx_25040111_lsu with hand-computed expectations.
module tb_ysyx_25040111_lsu;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_men;
    logic        in_write;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_mask;
    logic        in_rsign;
    logic [4:0]  in_ard;
    logic [31:0] in_rd;
    logic        in_gen;
    logic [11:0] in_acsr;
    logic [31:0] in_csr;
    logic        in_sen;
    logic [31:0] in_pc;
    logic        in_err;
    logic [3:0]  in_errtp;
    logic        finish;
    logic [4:0]  frd;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        err_o;
    logic [3:0]  errtp_o;
    logic [31:0] err_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_checks;
    int n_fail;

    ysyx_25040111_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_men(in_men), .in_write(in_write),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_mask(in_mask), .in_rsign(in_rsign),
        .in_ard(in_ard), .in_rd(in_rd), .in_gen(in_gen), .in_acsr(in_acsr),
        .in_csr(in_csr), .in_sen(in_sen), .in_pc(in_pc), .in_err(in_err), .in_errtp(in_errtp),
        .finish(finish), .frd(frd), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr),
        .gpr_wdata(gpr_wdata), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .err_o(err_o), .errtp_o(errtp_o), .err_pc(err_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_op();
        in_valid = 1'b0; in_men = 1'b0; in_write = 1'b0; in_addr = '0; in_wdata = '0;
        in_mask = 2'b00; in_rsign = 1'b0; in_ard = '0; in_rd = '0; in_gen = 1'b0;
        in_acsr = '0; in_csr = '0; in_sen = 1'b0; in_pc = '0; in_err = 1'b0; in_errtp = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_op();
        arready = 0; rdata = '0; rresp = 2'b00; rvalid = 0;
        awready = 0; wready = 0; bresp = 2'b00; bvalid = 0;
        reset = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_finish", finish, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        reset = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // ALU op with CSR write: commit one cycle after accept
        in_valid = 1; in_gen = 1; in_ard = 5'd5; in_rd = 32'h1234;
        in_sen = 1; in_acsr = 12'h300; in_csr = 32'hDEAD_BEEF; in_pc = 32'h8000_0100;
        tick();
        clear_op();
        chk("alu_finish", finish, 1);
        chk("alu_gpr_wen", gpr_wen, 1);
        chk("alu_gpr_waddr", gpr_waddr, 5);
        chk("alu_gpr_wdata", gpr_wdata, 32'h1234);
        chk("alu_frd", frd, 5);
        chk("alu_csr_wen", csr_wen, 1);
        chk("alu_csr_waddr", csr_waddr, 12'h300);
        chk("alu_csr_wdata", csr_wdata, 32'hDEAD_BEEF);
        chk("alu_err", err_o, 0);
        chk("alu_arvalid", arvalid, 0);
        chk("alu_awvalid", awvalid, 0);
        chk("alu_in_ready", in_ready, 0);
        tick();
        chk("alu_finish_drop", finish, 0);
        chk("alu_back_ready", in_ready, 1);

        // Signed byte load at lane 3, with one arready wait cycle
        in_valid = 1; in_men = 1; in_addr = 32'h8000_0003; in_mask = 2'b00;
        in_rsign = 1; in_gen = 1; in_ard = 5'd10;
        tick();
        clear_op();
        chk("lb_arvalid", arvalid, 1);
        chk("lb_araddr", araddr, 32'h8000_0000);
        tick();
        chk("lb_arvalid_hold", arvalid, 1);
        arready = 1;
        tick();
        arready = 0;
        chk("lb_arvalid_drop", arvalid, 0);
        chk("lb_rready", rready, 1);
        rvalid = 1; rdata = 32'h80FF_FF00;
        tick();
        rvalid = 0;
        chk("lb_finish", finish, 1);
        chk("lb_gpr_wdata", gpr_wdata, 32'hFFFF_FF80);
        chk("lb_gpr_wen", gpr_wen, 1);
        chk("lb_frd", frd, 10);
        tick();

        // Same load, zero-extended, zero wait states: commit 3 cycles after accept
        in_valid = 1; in_men = 1; in_addr = 32'h8000_0003; in_mask = 2'b00;
        in_rsign = 0; in_gen = 1; in_ard = 5'd10;
        arready = 1;
        tick();
        clear_op();
        tick();
        arready = 0; rvalid = 1; rdata = 32'h80FF_FF00;
        chk("lbu_not_yet", finish, 0);
        tick();
        rvalid = 0;
        chk("lbu_finish", finish, 1);
        chk("lbu_gpr_wdata", gpr_wdata, 32'h0000_0080);
        tick();

        // Half store at lane 2; awready arrives 3 cycles after wready
        in_valid = 1; in_men = 1; in_write = 1; in_addr = 32'h8000_0002;
        in_wdata = 32'h0000_ABCD; in_mask = 2'b01; in_gen = 0; in_ard = 5'd9;
        tick();
        clear_op();
        chk("sh_awvalid", awvalid, 1);
        chk("sh_wvalid", wvalid, 1);
        chk("sh_wdata", wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", wstrb, 4'b1100);
        wready = 1;
        tick();
        wready = 0;
        chk("sh_wvalid_drop", wvalid, 0);
        chk("sh_awvalid_hold", awvalid, 1);
        tick(); tick();
        chk("sh_awvalid_hold2", awvalid, 1);
        awready = 1;
        tick();
        awready = 0;
        chk("sh_awvalid_drop", awvalid, 0);
        chk("sh_bready", bready, 1);
        chk("sh_no_finish", finish, 0);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("sh_finish", finish, 1);
        chk("sh_frd", frd, 0);
        chk("sh_gpr_wen", gpr_wen, 0);
        chk("sh_err", err_o, 0);
        tick();
        chk("sh_single_commit", finish, 0);

        // Word store, both handshakes together, bus error response
        in_valid = 1; in_men = 1; in_write = 1; in_addr = 32'h0000_0010;
        in_wdata = 32'h1122_3344; in_mask = 2'b10; in_pc = 32'h44;
        awready = 1; wready = 1;
        tick();
        clear_op();
        chk("sw_wstrb", wstrb, 4'b1111);
        chk("sw_wdata", wdata, 32'h1122_3344);
        tick();
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        chk("sw_bready", bready, 1);
        tick();
        bvalid = 0; bresp = 2'b00;
        chk("sw_finish", finish, 1);
        chk("sw_err", err_o, 1);
        chk("sw_errtp", errtp_o, 7);
        tick();

        // Misaligned word load: no bus activity, exception type 4
        in_valid = 1; in_men = 1; in_addr = 32'h0000_0001; in_mask = 2'b10;
        in_gen = 1; in_ard = 5'd3; in_pc = 32'h8000_0200;
        tick();
        clear_op();
        chk("mis_arvalid", arvalid, 0);
        chk("mis_finish", finish, 1);
        chk("mis_err", err_o, 1);
        chk("mis_errtp", errtp_o, 4);
        chk("mis_gpr_wen", gpr_wen, 0);
        chk("mis_err_pc", err_pc, 32'h8000_0200);
        tick();

        // Misaligned half store: exception type 6
        in_valid = 1; in_men = 1; in_write = 1; in_addr = 32'h0000_0003; in_mask = 2'b01;
        tick();
        clear_op();
        chk("mis_st_awvalid", awvalid, 0);
        chk("mis_st_errtp", errtp_o, 6);
        tick();

        // Read error response on load to x7
        in_valid = 1; in_men = 1; in_addr = 32'h0000_0010; in_mask = 2'b10;
        in_gen = 1; in_ard = 5'd7;
        arready = 1;
        tick();
        clear_op();
        tick();
        arready = 0; rvalid = 1; rresp = 2'b10; rdata = 32'h5555_5555;
        tick();
        rvalid = 0; rresp = 2'b00;
        chk("rerr_finish", finish, 1);
        chk("rerr_err", err_o, 1);
        chk("rerr_errtp", errtp_o, 5);
        chk("rerr_gpr_wen", gpr_wen, 0);
        chk("rerr_frd", frd, 7);
        tick();

        // Upstream exception on a memory op bypasses the bus
        in_valid = 1; in_men = 1; in_err = 1; in_errtp = 4'd3; in_addr = 32'h0000_0020;
        in_sen = 1; in_pc = 32'h8000_0300;
        tick();
        clear_op();
        chk("uerr_arvalid", arvalid, 0);
        chk("uerr_awvalid", awvalid, 0);
        chk("uerr_finish", finish, 1);
        chk("uerr_errtp", errtp_o, 3);
        chk("uerr_csr_wen", csr_wen, 0);
        tick();

        // Reset asserted while waiting in RDATA
        in_valid = 1; in_men = 1; in_addr = 32'h0000_0040; in_mask = 2'b10; in_gen = 1; in_ard = 5'd8;
        arready = 1;
        tick();
        clear_op();
        tick();
        arready = 0;
        chk("mid_rready", rready, 1);
        reset = 0;
        #1;
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_finish", finish, 0);
        tick();
        reset = 1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_finish", finish, 0);
        chk("post_rst_frd", frd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
